// File: rtl/cam_capture_fmt.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture_fmt
// Brief    : OV7670 RGB565 capture front end with RGB332/gray/test-bar output,
//            windowing, integer decimation and frame status; drives FB write port.
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture_fmt #(
    parameter int AW       = 17,
    parameter int DW       = 8,
    parameter int SCREEN_X = 160,
    parameter int SCREEN_Y = 120,
    parameter int DECIM    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic          short_frame,
    output logic          overflow,
    output logic          busy
);

    localparam int XW    = $clog2(SCREEN_X + 1);
    localparam int YW    = $clog2(SCREEN_Y + 1);
    localparam int CW    = $clog2(SCREEN_X * SCREEN_Y + 1);
    localparam int BAR_W = SCREEN_X / 8;
    localparam int BPW   = $clog2(BAR_W) + 1;

    localparam logic [1:0]     c_dmask    = 2'(DECIM - 1);
    localparam logic [XW-1:0]  c_sx       = XW'(SCREEN_X);
    localparam logic [YW-1:0]  c_sy       = YW'(SCREEN_Y);
    localparam logic [CW-1:0]  c_total    = CW'(SCREEN_X * SCREEN_Y);
    localparam logic [AW-1:0]  c_row_step = AW'(SCREEN_X);
    localparam logic [BPW-1:0] c_bar_last = BPW'(BAR_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_vsync_d, r_href_d;
    logic [1:0]      r_mode;
    logic            r_phase;
    logic [7:0]      r_byte1;
    logic [1:0]      r_src_x, r_src_y;
    logic [XW-1:0]   r_x_out;
    logic [YW-1:0]   r_y_out;
    logic [AW-1:0]   r_row_base;
    logic [CW-1:0]   r_wr_cnt;
    logic [2:0]      r_bar;
    logic [BPW-1:0]  r_bar_px;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_data;
    logic            r_px_wr, r_frame_done, r_short, r_overflow, r_busy;
    logic [7:0]      r_frame_cnt;

    logic            w_vs_fall, w_vs_rise, w_hr_fall;
    logic            w_byte2, w_keep, w_line_kept, w_in_win, w_write;
    logic [7:0]      w_rgb332, w_gray, w_bar_px, w_pix;
    logic [CW-1:0]   w_wr_total;

    assign w_vs_fall   = r_vsync_d & ~vsync;
    assign w_vs_rise   = ~r_vsync_d & vsync;
    assign w_hr_fall   = r_href_d & ~href;
    assign w_byte2     = (r_state == ST_FRAME) & href & r_phase;
    assign w_line_kept = (r_src_y & c_dmask) == 2'd0;
    assign w_keep      = ((r_src_x & c_dmask) == 2'd0) && w_line_kept;
    assign w_in_win    = (r_x_out < c_sx) && (r_y_out < c_sy);
    assign w_write     = w_byte2 & w_keep & w_in_win;
    assign w_wr_total  = r_wr_cnt + CW'(w_write);

    assign w_rgb332 = {r_byte1[7:5], r_byte1[2:0], px_data[4:3]};
    // The two LSBs of R8 + 2*G8 + B8 are always zero, so summing the pre-shifted
    // terms yields bits [9:2] of the full 10-bit sum exactly.
    assign w_gray = {2'b00, r_byte1[7:3], 1'b0}
                  + {1'b0, r_byte1[2:0], px_data[7:5], 1'b0}
                  + {2'b00, px_data[4:0], 1'b0};

    always_comb begin
        w_bar_px = 8'h00;
        case (r_bar)
            3'd0: w_bar_px = 8'hFF;
            3'd1: w_bar_px = 8'hFC;
            3'd2: w_bar_px = 8'h1F;
            3'd3: w_bar_px = 8'h1C;
            3'd4: w_bar_px = 8'hE3;
            3'd5: w_bar_px = 8'hE0;
            3'd6: w_bar_px = 8'h03;
            default: w_bar_px = 8'h00;
        endcase
    end

    always_comb begin
        w_pix = w_rgb332;
        case (r_mode)
            2'b01:   w_pix = w_gray;
            2'b10:   w_pix = w_bar_px;
            default: w_pix = w_rgb332;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_vsync_d    <= 1'b0;
            r_href_d     <= 1'b0;
            r_mode       <= 2'b00;
            r_phase      <= 1'b0;
            r_byte1      <= 8'h00;
            r_src_x      <= 2'd0;
            r_src_y      <= 2'd0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_row_base   <= '0;
            r_wr_cnt     <= '0;
            r_bar        <= 3'd0;
            r_bar_px     <= '0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_px_wr      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'h00;
            r_short      <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_vsync_d    <= vsync;
            r_href_d     <= href;
            r_px_wr      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_fall && enable) begin
                        r_state    <= ST_FRAME;
                        r_busy     <= 1'b1;
                        r_mode     <= (mode == 2'b11) ? 2'b00 : mode;
                        r_phase    <= 1'b0;
                        r_src_x    <= 2'd0;
                        r_src_y    <= 2'd0;
                        r_x_out    <= '0;
                        r_y_out    <= '0;
                        r_row_base <= '0;
                        r_wr_cnt   <= '0;
                        r_bar      <= 3'd0;
                        r_bar_px   <= '0;
                    end
                end
                default: begin
                    if (href) begin
                        if (!r_phase) begin
                            r_byte1 <= px_data;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            r_src_x <= r_src_x + 2'd1;
                            if (w_write) begin
                                r_px_wr    <= 1'b1;
                                r_mem_addr <= r_row_base + AW'(r_x_out);
                                r_mem_data <= DW'(w_pix);
                                r_x_out    <= r_x_out + 1'b1;
                                r_wr_cnt   <= w_wr_total;
                                if (r_bar_px == c_bar_last) begin
                                    r_bar_px <= '0;
                                    r_bar    <= r_bar + 3'd1;
                                end else begin
                                    r_bar_px <= r_bar_px + 1'b1;
                                end
                            end else if (w_keep) begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end else if (w_hr_fall) begin
                        r_phase  <= 1'b0;
                        r_src_x  <= 2'd0;
                        r_src_y  <= r_src_y + 2'd1;
                        r_bar    <= 3'd0;
                        r_bar_px <= '0;
                        // y_out saturates so excess lines cannot wrap back into the window
                        if (w_line_kept) begin
                            r_x_out <= '0;
                            if (r_y_out < c_sy) begin
                                r_y_out    <= r_y_out + 1'b1;
                                r_row_base <= r_row_base + c_row_step;
                            end
                        end
                    end
                    if (w_vs_rise) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 8'd1;
                        r_short      <= (w_wr_total != c_total);
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mem_px_addr = r_mem_addr;
    assign mem_px_data = r_mem_data;
    assign px_wr       = r_px_wr;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign short_frame = r_short;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_fmt.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture_fmt
// Brief    : Directed self-checking bench for cam_capture_fmt (DECIM 1 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_capture_fmt;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1, en2, vsync, href;
    logic [1:0]  mode;
    logic [7:0]  px_data;

    logic [16:0] addr1;
    logic [7:0]  data1, fcnt1;
    logic        wr1, fd1, sf1, ov1, busy1;
    logic [6:0]  addr2;
    logic [7:0]  data2, fcnt2;
    logic        wr2, fd2, sf2, ov2, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem1 [0:19199];
    logic [15:0] tbl [0:3];
    logic        chk_data;
    logic [7:0]  exp_data;
    int m1_idx, m1_bad_addr, m1_bad_data, m1_oob, m1_consec, m1_done;
    int m2_idx, m2_bad, m2_gap, m2_gap_viol, m2_done;
    logic prev_wr1 = 1'b0;

    always #5 clk = ~clk;

    cam_capture_fmt u_dut1 (
        .clk(clk), .rst(rst), .enable(en1), .mode(mode), .vsync(vsync), .href(href),
        .px_data(px_data), .mem_px_addr(addr1), .mem_px_data(data1), .px_wr(wr1),
        .frame_done(fd1), .frame_cnt(fcnt1), .short_frame(sf1), .overflow(ov1), .busy(busy1)
    );

    cam_capture_fmt #(.AW(7), .DW(8), .SCREEN_X(16), .SCREEN_Y(8), .DECIM(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en2), .mode(mode), .vsync(vsync), .href(href),
        .px_data(px_data), .mem_px_addr(addr2), .mem_px_data(data2), .px_wr(wr2),
        .frame_done(fd2), .frame_cnt(fcnt2), .short_frame(sf2), .overflow(ov2), .busy(busy2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        m1_idx = 0; m1_bad_addr = 0; m1_bad_data = 0; m1_oob = 0; m1_consec = 0; m1_done = 0;
        m2_idx = 0; m2_bad = 0; m2_gap = 100; m2_gap_viol = 0; m2_done = 0;
    endtask

    // kind 0: constant F8,00; kind 1: stored RGB332 value encodes {src_y[2:0], src_x[4:0]}; else table
    function automatic logic [15:0] make_px(input int kind, input int x, input int y);
        logic [7:0] v;
        if (kind == 0) return 16'hF800;
        if (kind == 1) begin
            v = {3'(y), 5'(x)};
            return {v[7:5], 2'b00, v[4:2], 3'b000, v[1:0], 3'b000};
        end
        return tbl[x % 4];
    endfunction

    task automatic drive_frame(input int lines, input int pix, input int kind);
        logic [15:0] p;
        vsync = 1'b1; repeat (3) @(negedge clk);
        vsync = 1'b0; repeat (3) @(negedge clk);
        for (int y = 0; y < lines; y++) begin
            href = 1'b1;
            for (int x = 0; x < pix; x++) begin
                p = make_px(kind, x, y);
                px_data = p[15:8]; @(negedge clk);
                px_data = p[7:0];  @(negedge clk);
            end
            href = 1'b0; px_data = 8'h00;
            repeat (2) @(negedge clk);
        end
        vsync = 1'b1; repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (wr1) begin
            if (addr1 != 17'(m1_idx)) m1_bad_addr++;
            if (chk_data && data1 != exp_data) m1_bad_data++;
            if (addr1 < 17'd19200) mem1[addr1] = data1;
            else m1_oob++;
            if (prev_wr1) m1_consec++;
            m1_idx++;
        end
        if (fd1) m1_done++;
        prev_wr1 = wr1;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        m2_gap++;
        if (wr2) begin
            e = {3'((m2_idx / 16) * 2), 5'((m2_idx % 16) * 2)};
            if (addr2 != 7'(m2_idx) || data2 != e) m2_bad++;
            if (m2_gap < 4) m2_gap_viol++;
            m2_gap = 0;
            m2_idx++;
        end
        if (fd2) m2_done++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en1 = 1'b0; en2 = 1'b0; vsync = 1'b1; href = 1'b0;
        mode = 2'b00; px_data = 8'h00; chk_data = 1'b0; exp_data = 8'h00;
        tbl[0] = 16'h0; tbl[1] = 16'h0; tbl[2] = 16'h0; tbl[3] = 16'h0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_val("rst_wr", 32'(wr1), 32'd0);
        check_val("rst_addr_data", {7'd0, addr1, data1}, 32'd0);
        check_val("rst_cnt", 32'(fcnt1), 32'd0);
        check_val("rst_flags", {28'd0, ov1, sf1, busy1, fd1}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Full 160x120 RGB332 frame; enable dropped mid-frame must not matter
        clear_mon(); en1 = 1'b1; mode = 2'b00; chk_data = 1'b1; exp_data = 8'hE0;
        fork
            drive_frame(120, 160, 0);
            begin
                repeat (400) @(negedge clk);
                check_val("busy_mid", 32'(busy1), 32'd1);
                en1 = 1'b0;
            end
        join
        en1 = 1'b1;
        check_val("full_writes", 32'(m1_idx), 32'd19200);
        check_val("full_bad_addr", 32'(m1_bad_addr), 32'd0);
        check_val("full_bad_data", 32'(m1_bad_data), 32'd0);
        check_val("full_consec", 32'(m1_consec), 32'd0);
        check_val("full_done", 32'(m1_done), 32'd1);
        check_val("full_fcnt", 32'(fcnt1), 32'd1);
        check_val("full_short", 32'(sf1), 32'd0);
        check_val("full_ovf", 32'(ov1), 32'd0);
        check_val("full_busy", 32'(busy1), 32'd0);

        // Colour bars, two lines, short frame
        clear_mon(); mode = 2'b10; chk_data = 1'b0;
        drive_frame(2, 160, 0);
        check_val("bar_0", 32'(mem1[0]), 32'hFF);
        check_val("bar_20", 32'(mem1[20]), 32'hFC);
        check_val("bar_40", 32'(mem1[40]), 32'h1F);
        check_val("bar_159", 32'(mem1[159]), 32'h00);
        check_val("bar_160", 32'(mem1[160]), 32'hFF);
        check_val("bar_fcnt", 32'(fcnt1), 32'd2);
        check_val("bar_short", 32'(sf1), 32'd1);

        // Format vectors: RGB332, gray, mode 11 behaves as RGB332
        clear_mon(); mode = 2'b00; tbl[0] = 16'h07E0; tbl[1] = 16'h001F;
        drive_frame(1, 2, 2);
        check_val("rgb_writes", 32'(m1_idx), 32'd2);
        check_val("rgb_restart_addr", 32'(m1_bad_addr), 32'd0);
        check_val("rgb_07E0", 32'(mem1[0]), 32'h1C);
        check_val("rgb_001F", 32'(mem1[1]), 32'h03);
        clear_mon(); mode = 2'b01; tbl[0] = 16'hFFFF; tbl[1] = 16'h0000;
        drive_frame(1, 2, 2);
        check_val("gray_FFFF", 32'(mem1[0]), 32'hFA);
        check_val("gray_0000", 32'(mem1[1]), 32'h00);
        clear_mon(); mode = 2'b11; tbl[0] = 16'hF800; tbl[1] = 16'h07E0;
        drive_frame(1, 2, 2);
        check_val("mode3_F800", 32'(mem1[0]), 32'hE0);
        check_val("mode3_07E0", 32'(mem1[1]), 32'h1C);

        // 200-pixel lines: columns 160..199 dropped, overflow sticky
        clear_mon(); mode = 2'b00; chk_data = 1'b1; exp_data = 8'hE0;
        drive_frame(3, 200, 0);
        check_val("ovf_writes", 32'(m1_idx), 32'd480);
        check_val("ovf_bad_addr", 32'(m1_bad_addr), 32'd0);
        check_val("ovf_bad_data", 32'(m1_bad_data), 32'd0);
        check_val("ovf_oob", 32'(m1_oob), 32'd0);
        check_val("ovf_flag", 32'(ov1), 32'd1);
        check_val("ovf_short", 32'(sf1), 32'd1);

        // Asynchronous reset mid-line, then restart at the next vsync fall
        clear_mon(); chk_data = 1'b0;
        fork
            drive_frame(2, 160, 0);
            begin
                repeat (60) @(negedge clk);
                #2 rst = 1'b0;
                #1;
                check_val("arst_wr", 32'(wr1), 32'd0);
                check_val("arst_addr_data", {7'd0, addr1, data1}, 32'd0);
                check_val("arst_cnt", 32'(fcnt1), 32'd0);
                check_val("arst_flags", {28'd0, ov1, sf1, busy1, fd1}, 32'd0);
                repeat (5) @(negedge clk);
                rst = 1'b1;
                #2 clear_mon();
            end
        join
        check_val("arst_partial_writes", 32'(m1_idx), 32'd0);
        check_val("arst_partial_done", 32'(m1_done), 32'd0);
        clear_mon(); chk_data = 1'b1; exp_data = 8'hE0;
        drive_frame(1, 4, 0);
        check_val("arst_next_writes", 32'(m1_idx), 32'd4);
        check_val("arst_next_addr", 32'(m1_bad_addr), 32'd0);
        check_val("arst_next_fcnt", 32'(fcnt1), 32'd1);

        // DECIM 2 instance: 32x16 source into 16x8 window
        en1 = 1'b0; en2 = 1'b1; mode = 2'b00; chk_data = 1'b0;
        clear_mon();
        drive_frame(16, 32, 1);
        check_val("dec_writes", 32'(m2_idx), 32'd128);
        check_val("dec_bad", 32'(m2_bad), 32'd0);
        check_val("dec_gap", 32'(m2_gap_viol), 32'd0);
        check_val("dec_done", 32'(m2_done), 32'd1);
        check_val("dec_fcnt", 32'(fcnt2), 32'd1);
        check_val("dec_short", 32'(sf2), 32'd0);
        check_val("dec_ovf", 32'(ov2), 32'd0);
        check_val("dec_dut1_idle", 32'(m1_idx), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
